// File: rtl/seg7_scan.sv
// Multiplexed scan controller for a common-anode 7-segment display.
// Steps through DIGITS nibbles, one slot of DIV cycles each, with frame-aligned word loads.
module seg7_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GUARD  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    output logic                  load_ack,
    input  logic                  blank_lz,
    output logic [3:0]            nibble,
    output logic                  blank,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);

    logic [PW-1:0]         presc_q, presc_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  blank_q, blank_d;
    logic [3:0]            nibble_q, nibble_d;

    logic [DIGITS-1:0]     zero_from;
    logic                  lz_blank;
    logic                  dark;

    assign frame    = (presc_q == PRESC_LAST) && (digit_q == DIGIT_LAST);
    // Reset wins over a coincident load, so no ack is reported in a reset cycle.
    assign load_ack = frame && load && !rst;

    // zero_from[i]: nibbles i..DIGITS-1 of the display word are all zero.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        zero_from = '0;
        for (int i = 0; i < DIGITS; i++) begin
            zero_from[i] = ((disp_q >> (4 * i)) == '0);
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        digit_d = digit_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        end
        disp_d = load_ack ? value : disp_q;
    end

    // Digit 0 is never blanked so an all-zero word still shows a single "0".
    assign lz_blank = blank_lz && (digit_q != '0) && zero_from[digit_q];
    assign dark     = (presc_q < GUARD_END) || lz_blank;

    always_comb begin
        an_d     = dark ? '1 : ~(DIGITS'(1) << digit_q);
        blank_d  = dark;
        nibble_d = disp_q[4*digit_q +: 4];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            digit_q  <= '0;
            disp_q   <= '0;
            an_q     <= '1;
            blank_q  <= 1'b1;
            nibble_q <= '0;
        end else begin
            presc_q  <= presc_d;
            digit_q  <= digit_d;
            disp_q   <= disp_d;
            an_q     <= an_d;
            blank_q  <= blank_d;
            nibble_q <= nibble_d;
        end
    end

    assign an     = an_q;
    assign blank  = blank_q;
    assign nibble = nibble_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIGITS=4, DIV=8, GUARD=2).
// A cycle model pushes expected registered outputs to a scoreboard; directed checks cover the scenarios.
module tb_seg7_scan;

    typedef struct packed {
        logic [3:0] an;
        logic       blank;
        logic [3:0] nibble;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        load_ack;
    logic        blank_lz = 1'b0;
    logic [3:0]  nibble;
    logic        blank;
    logic [3:0]  an;
    logic        frame;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int          m_presc = 0;
    int          m_digit = 0;
    logic [15:0] m_disp  = '0;
    logic        m_valid = 1'b0;
    logic        vary    = 1'b0;

    exp_t sb_q[$];
    int   ack_log[$];

    seg7_scan #(.DIGITS(4), .DIV(8), .GUARD(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .load_ack (load_ack),
        .blank_lz (blank_lz),
        .nibble   (nibble),
        .blank    (blank),
        .an       (an),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp_v);
    endtask

    // One clock: check combinational outputs, push expected registered outputs, advance, pop and compare.
    task automatic cycle();
        exp_t e;
        logic m_frame;
        logic m_ack;
        logic dark;
        m_frame = (m_presc == 7) && (m_digit == 3);
        m_ack   = m_frame && load && !rst;
        if (m_valid) begin
            check("frame", frame, m_frame);
            check("load_ack", load_ack, m_ack);
        end
        if (load_ack === 1'b1) ack_log.push_back(cyc);
        if (rst) begin
            e = '{4'hf, 1'b1, 4'h0};
        end else begin
            dark     = (m_presc < 2) || (blank_lz && m_digit != 0 && (m_disp >> (4 * m_digit)) == 16'h0);
            e.an     = dark ? 4'hf : ~(4'b0001 << m_digit);
            e.blank  = dark;
            e.nibble = m_disp[4*m_digit +: 4];
        end
        sb_q.push_back(e);

        @(posedge clk);
        #1;

        if (rst) begin
            m_presc = 0;
            m_digit = 0;
            m_disp  = '0;
            m_valid = 1'b1;
            cyc     = 0;
        end else begin
            if (m_ack) m_disp = value;
            if (m_presc == 7) begin
                m_presc = 0;
                m_digit = (m_digit == 3) ? 0 : m_digit + 1;
            end else begin
                m_presc++;
            end
            cyc++;
        end
        if (vary) value = 16'($urandom);

        e = sb_q.pop_front();
        if (m_valid) begin
            check("an", an, e.an);
            check("blank", blank, e.blank);
            check("nibble", nibble, e.nibble);
            check("an_onehot", ($countones(~an) <= 1), 1);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Present a word with load held until acked (bounded), then drop load at the start of the next frame.
    task automatic load_word(input logic [15:0] w);
        logic got;
        got   = 1'b0;
        value = w;
        load  = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (load_ack === 1'b1) got = 1'b1;
            else cycle();
        end
        check("load_word_ack_seen", got, 1);
        cycle();
        load = 1'b0;
    endtask

    // Watch one frame's worth of cycles: which digits light, and the nibble each showed.
    task automatic observe_frame(output logic [3:0] lit, output logic [15:0] nibs);
        lit  = '0;
        nibs = '0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            for (int j = 0; j < 4; j++) begin
                if (an[j] == 1'b0) begin
                    lit[j] = 1'b1;
                    nibs[4*j +: 4] = nibble;
                end
            end
        end
    endtask

    initial begin
        logic [3:0]  lit;
        logic [15:0] nibs;
        logic [15:0] v_cap;

        // Reset and rotation
        do_reset();
        check("rot_c0_an", an, 4'hf);
        check("rot_c0_blank", blank, 1);
        run_to(2);  check("rot_c2_an", an, 4'hf);
        run_to(3);  check("rot_c3_an", an, 4'he);
        check("rot_c3_blank", blank, 0);
        run_to(8);  check("rot_c8_an", an, 4'he);
        run_to(9);  check("rot_c9_an", an, 4'hf);
        run_to(10); check("rot_c10_an", an, 4'hf);
        run_to(11); check("rot_c11_an", an, 4'hd);
        run_to(16); check("rot_c16_an", an, 4'hd);
        run_to(19); check("rot_c19_an", an, 4'hb);
        run_to(27); check("rot_c27_an", an, 4'h7);
        run_to(34); check("rot_c34_an", an, 4'hf);
        run_to(35); check("rot_c35_an", an, 4'he);

        // Frame-aligned load
        do_reset();
        value = 16'h1234;
        load  = 1'b1;
        run_to(30); check("fl_c30_frame", frame, 0);
        run_to(31); check("fl_c31_frame", frame, 1);
        check("fl_c31_ack", load_ack, 1);
        cycle();
        load = 1'b0;
        check("fl_c32_disp", dut.disp_q, 16'h1234);
        run_to(33); check("fl_c33_nibble", nibble, 4);
        check("fl_c33_an", an, 4'hf);
        run_to(35); check("fl_c35_an", an, 4'he);
        run_to(43); check("fl_c43_nibble", nibble, 3);
        check("fl_c43_an", an, 4'hd);
        run_to(51); check("fl_c51_nibble", nibble, 2);
        run_to(59); check("fl_c59_nibble", nibble, 1);
        check("fl_c59_an", an, 4'h7);

        // Dropped request
        do_reset();
        ack_log.delete();
        run_to(10);
        value = 16'habcd;
        load  = 1'b1;
        run_to(13);
        load = 1'b0;
        run_to(43);
        check("drop_ack_count", ack_log.size(), 0);
        check("drop_disp", dut.disp_q, 16'h0);
        check("drop_c43_nibble", nibble, 0);
        check("drop_c43_an", an, 4'hd);

        // Leading-zero blanking
        blank_lz = 1'b1;
        load_word(16'h0050);
        observe_frame(lit, nibs);
        check("lz50_lit", lit, 4'b0011);
        check("lz50_nib1", nibs[7:4], 5);
        check("lz50_nib0", nibs[3:0], 0);
        load_word(16'h0000);
        observe_frame(lit, nibs);
        check("lz0_lit", lit, 4'b0001);
        check("lz0_nib0", nibs[3:0], 0);
        blank_lz = 1'b0;
        observe_frame(lit, nibs);
        check("nolz_lit", lit, 4'b1111);

        // Reset mid-scan
        load_word(16'h1234);
        run_to(cyc + 21);
        check("mid_digit_pre", dut.digit_q, 2);
        check("mid_presc_pre", dut.presc_q, 5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_presc", dut.presc_q, 0);
        check("mid_digit", dut.digit_q, 0);
        cycle();
        check("mid_an", an, 4'hf);
        check("mid_blank", blank, 1);
        check("mid_nibble", nibble, 0);
        check("mid_disp", dut.disp_q, 16'h0);

        // Back-to-back frames
        do_reset();
        ack_log.delete();
        load = 1'b1;
        vary = 1'b1;
        run_to(31);
        v_cap = value;
        check("b2b_ack31", load_ack, 1);
        cycle();
        check("b2b_disp32", dut.disp_q, v_cap);
        run_to(63);
        v_cap = value;
        check("b2b_ack63", load_ack, 1);
        cycle();
        check("b2b_disp64", dut.disp_q, v_cap);
        run_to(95);
        v_cap = value;
        check("b2b_ack95", load_ack, 1);
        cycle();
        check("b2b_disp96", dut.disp_q, v_cap);
        run_to(100);
        vary = 1'b0;
        load = 1'b0;
        check("b2b_ack_count", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            check("b2b_ack_cyc0", ack_log[0], 31);
            check("b2b_ack_cyc1", ack_log[1], 63);
            check("b2b_ack_cyc2", ack_log[2], 95);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
